// File: rtl/pcm_decode.sv
// Receive-side PCM deframer: serial 8-bit companded codes -> 13-bit sign-magnitude linear + 8-bit DA word.
// Code register loads on the 8th bit edge; outputs update one cycle later; no backpressure (bit_en strobed).
module pcm_decode #(
  parameter int FRAME_LEN = 8,
  parameter int MISS_MAX  = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic        clkAD,
  input  logic        reset,
  input  logic        bit_en,
  input  logic        pcm_bit,
  input  logic        frame_sync,
  output logic [12:0] linear_out,
  output logic [7:0]  daout,
  output logic        out_valid,
  output logic        locked,
  output logic        sync_err
);

  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_idx;
  logic [3:0]    r_miss, w_miss_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_code;
  logic          r_load, w_load;
  logic          r_sync_err, w_sync_err;
  logic          r_valid;
  logic [12:0]   r_linear;
  logic          w_take;
  logic          w_in_code;
  logic          w_last;
  logic [2:0]    w_bitpos;
  logic [11:0]   w_seg_mag;
  logic [11:0]   w_mag;

  always_ff @(posedge clkAD or posedge reset) begin
    if (reset) r_state <= HUNT;
    else       r_state <= w_state_nxt;
  end

  // w_idx is the bit position the current bit is treated as (realigned on sync)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_miss_nxt  = r_miss;
    w_shift_nxt = r_shift;
    w_idx       = r_cnt;
    w_take      = 1'b0;
    w_load      = 1'b0;
    w_sync_err  = 1'b0;
    w_in_code   = 1'b0;
    w_last      = 1'b0;
    w_bitpos    = 3'd0;
    if (bit_en) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_state_nxt = LOCK;
            w_miss_nxt  = 4'd0;
            w_idx       = '0;
            w_take      = 1'b1;
          end
        end
        LOCK: begin
          w_take = 1'b1;
          if (frame_sync) begin
            w_miss_nxt = 4'd0;
            w_idx      = '0;
            w_sync_err = (r_cnt != '0);
          end else if (r_cnt == '0) begin
            if (({1'b0, r_miss} + 5'd1) >= 5'(MISS_MAX)) begin
              w_state_nxt = HUNT;
              w_miss_nxt  = 4'd0;
              w_cnt_nxt   = '0;
              w_take      = 1'b0;
            end else begin
              w_miss_nxt = r_miss + 4'd1;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
    if (w_take) begin
      w_in_code = ((w_idx >> 3) == '0);
      w_last    = (w_idx == CW'(FRAME_LEN - 1));
      w_bitpos  = (MSB_FIRST != 0) ? (3'd7 - w_idx[2:0]) : w_idx[2:0];
      if (w_idx == '0) w_shift_nxt = 8'd0;
      if (w_in_code) w_shift_nxt[w_bitpos] = pcm_bit;
      w_load    = w_in_code && (w_idx[2:0] == 3'd7);
      w_cnt_nxt = w_last ? '0 : (w_idx + 1'b1);
    end
  end

  // Segment n>=1 places the implied leading one at bit n+4
  assign w_seg_mag = {6'd0, 1'b1, r_code[3:0], 1'b1} << (r_code[6:4] - 3'd1);
  assign w_mag     = (r_code[6:4] == 3'd0) ? {7'd0, r_code[3:0], 1'b1} : w_seg_mag;

  always_ff @(posedge clkAD or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_miss     <= 4'd0;
      r_shift    <= 8'd0;
      r_code     <= 8'd0;
      r_load     <= 1'b0;
      r_sync_err <= 1'b0;
      r_valid    <= 1'b0;
      r_linear   <= 13'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_miss     <= w_miss_nxt;
      r_shift    <= w_shift_nxt;
      r_load     <= w_load;
      r_sync_err <= w_sync_err;
      r_valid    <= r_load;
      if (w_load) r_code   <= w_shift_nxt;
      if (r_load) r_linear <= {r_code[7], w_mag};
    end
  end

  assign linear_out = r_linear;
  assign daout      = r_linear[12:5];
  assign out_valid  = r_valid;
  assign locked     = (r_state == LOCK);
  assign sync_err   = r_sync_err;

endmodule
